// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: result-source handshakes and RF write port of the writeback arbiter
// src_valid/src_addr/src_data : per-source results offered to the arbiter
// src_ready                   : per-source FIFO has room
// write_addrs/write_data      : registered RF write address and data
// write_reg_enable            : registered RF write strobe
// pending_mask                : registers with a buffered or in-flight write
// idle                        : nothing buffered and no write on the port
interface wb_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS),
    parameter int NUM_SRCS   = 3
);
    logic [NUM_SRCS-1:0]                 src_valid;
    logic [NUM_SRCS-1:0][ADDR_WIDTH-1:0] src_addr;
    logic [NUM_SRCS-1:0][DATA_WIDTH-1:0] src_data;
    logic [NUM_SRCS-1:0]                 src_ready;
    logic [ADDR_WIDTH-1:0]               write_addrs;
    logic [DATA_WIDTH-1:0]               write_data;
    logic                                write_reg_enable;
    logic [NUM_REGS-1:0]                 pending_mask;
    logic                                idle;
    modport master (
        output src_valid, src_addr, src_data,
        input  src_ready, write_addrs, write_data, write_reg_enable, pending_mask, idle
    );
    modport slave (
        input  src_valid, src_addr, src_data,
        output src_ready, write_addrs, write_data, write_reg_enable, pending_mask, idle
    );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: buffers results from NUM_SRCS units in per-source FIFOs and drains them round-robin to one RF write port
// clk, rst : clock and synchronous active-high reset
// bus      : wb_arbiter_if.slave carrying source handshakes, RF write port, pending_mask and idle
module wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS),
    parameter int NUM_SRCS   = 3,
    parameter int FIFO_DEPTH = 2
) (
    input logic        clk,
    input logic        rst,
    wb_arbiter_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int GW = NUM_SRCS > 1 ? $clog2(NUM_SRCS) : 1;
    logic [ADDR_WIDTH-1:0] fifo_addr [NUM_SRCS][FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [NUM_SRCS][FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr    [NUM_SRCS];
    logic [PW-1:0]         wr_ptr    [NUM_SRCS];
    logic [CW-1:0]         count     [NUM_SRCS];
    logic [GW-1:0]         last_grant;
    logic [GW-1:0]         gnt;
    logic [GW-1:0]         idx;
    logic                  gnt_valid;
    logic [NUM_SRCS-1:0]   push;
    logic [NUM_SRCS-1:0]   pop;
    logic [NUM_REGS-1:0]   pend;
    // Scan from farthest to nearest so the last hit is the first candidate after last_grant.
    always_comb begin
        gnt_valid = 1'b0;
        gnt = last_grant;
        idx = last_grant;
        for (int k = NUM_SRCS; k >= 1; k--) begin
            idx = GW'((int'(last_grant) + k) % NUM_SRCS);
            if (count[idx] != '0) begin
                gnt_valid = 1'b1;
                gnt = idx;
            end
        end
    end
    // Ready looks only at registered count; an x0 write completes the handshake without storing.
    always_comb begin
        bus.idle = !bus.write_reg_enable;
        for (int i = 0; i < NUM_SRCS; i++) begin
            bus.src_ready[i] = count[i] < CW'(FIFO_DEPTH);
            push[i] = bus.src_valid[i] && (count[i] < CW'(FIFO_DEPTH)) && (bus.src_addr[i] != '0);
            pop[i] = gnt_valid && (gnt == GW'(i));
            if (count[i] != '0) bus.idle = 1'b0;
        end
    end
    always_comb begin
        pend = '0;
        for (int i = 0; i < NUM_SRCS; i++)
            for (int j = 0; j < FIFO_DEPTH; j++)
                if (CW'(j) < count[i]) pend[fifo_addr[i][rd_ptr[i] + PW'(j)]] = 1'b1;
        if (bus.write_reg_enable) pend[bus.write_addrs] = 1'b1;
        pend[0] = 1'b0;
        bus.pending_mask = pend;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SRCS; i++) begin
                count[i]  <= '0;
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
            end
            last_grant           <= GW'(NUM_SRCS - 1);
            bus.write_reg_enable <= 1'b0;
            bus.write_addrs      <= '0;
            bus.write_data       <= '0;
        end else begin
            for (int i = 0; i < NUM_SRCS; i++) begin
                if (push[i]) begin
                    fifo_addr[i][wr_ptr[i]] <= bus.src_addr[i];
                    fifo_data[i][wr_ptr[i]] <= bus.src_data[i];
                    wr_ptr[i] <= wr_ptr[i] + PW'(1);
                end
                if (pop[i]) rd_ptr[i] <= rd_ptr[i] + PW'(1);
                count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
            end
            bus.write_reg_enable <= gnt_valid;
            if (gnt_valid) begin
                bus.write_addrs <= fifo_addr[gnt][rd_ptr[gnt]];
                bus.write_data  <= fifo_data[gnt][rd_ptr[gnt]];
                last_grant      <= gnt;
            end
        end
    end
endmodule
